// File: rtl/wired_dispatch_buf_if.sv
// Frontend-to-rename dispatch bundle interface: bundle handshake, flush/redirect
// control and occupancy. The buffer takes the slave side, the frontend the master side.
interface wired_dispatch_buf_if #(
    parameter int LANES     = 2,
    parameter int DEPTH     = 4,
    parameter int PKG_WIDTH = 64,
    parameter int TID_WIDTH = 1
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [LANES-1:0]           in_mask_i;
    logic [LANES*PKG_WIDTH-1:0] in_pkg_i;
    logic [TID_WIDTH-1:0]       in_tid_i;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [LANES-1:0]           out_mask_o;
    logic [LANES*PKG_WIDTH-1:0] out_pkg_o;
    logic                       flush_i;
    logic                       redirect_valid_i;
    logic [TID_WIDTH-1:0]       redirect_tid_i;
    logic [CNT_W-1:0]           count_o;

    modport master (
        output in_valid_i, in_mask_i, in_pkg_i, in_tid_i, out_ready_i,
               flush_i, redirect_valid_i, redirect_tid_i,
        input  in_ready_o, out_valid_o, out_mask_o, out_pkg_o, count_o
    );

    modport slave (
        input  in_valid_i, in_mask_i, in_pkg_i, in_tid_i, out_ready_i,
               flush_i, redirect_valid_i, redirect_tid_i,
        output in_ready_o, out_valid_o, out_mask_o, out_pkg_o, count_o
    );
endinterface

// File: rtl/wired_dispatch_buf.sv
// Dispatch bundle FIFO between fetch/decode and rename, with flush-time capture of a
// same-path bundle. Define WIRED_DBUF_BYPASS_EN to add an empty-FIFO zero-latency bypass.
module wired_dispatch_buf #(
    parameter int LANES     = 2,
    parameter int DEPTH     = 4,
    parameter int PKG_WIDTH = 64,
    parameter int TID_WIDTH = 1
) (
    input logic                clk,
    input logic                rst,
    wired_dispatch_buf_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BUS_W = LANES * PKG_WIDTH;

    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [TID_WIDTH-1:0] cur_tid_q, cur_tid_d;

    logic [LANES-1:0]     mask_mem [DEPTH];
    logic [BUS_W-1:0]     pkg_mem  [DEPTH];

    logic                 fifo_empty;
    logic                 mask_nz;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 flush_keep;
    logic                 wr_en;
    logic                 byp_take;
    logic [TID_WIDTH-1:0] cmp_tid;

    assign fifo_empty     = (count_q == '0);
    assign mask_nz        = |bus.in_mask_i;
    assign bus.in_ready_o = (count_q < CNT_W'(DEPTH));
    assign bus.count_o    = count_q;
    assign accept         = bus.in_valid_i && bus.in_ready_o;

    // A redirect arriving in the flush cycle already names the surviving path.
    assign cmp_tid    = bus.redirect_valid_i ? bus.redirect_tid_i : cur_tid_q;
    assign flush_keep = accept && mask_nz && (bus.in_tid_i == cmp_tid);

    assign pop = !fifo_empty && bus.out_ready_i && !bus.flush_i;

`ifdef WIRED_DBUF_BYPASS_EN
    logic byp_sel;
    assign byp_sel         = fifo_empty && !bus.flush_i && mask_nz;
    assign byp_take        = byp_sel && bus.in_valid_i && bus.out_ready_i;
    assign bus.out_valid_o = byp_sel ? bus.in_valid_i : !fifo_empty;
    assign bus.out_mask_o  = byp_sel ? bus.in_mask_i  : mask_mem[head_q];
    assign bus.out_pkg_o   = byp_sel ? bus.in_pkg_i   : pkg_mem[head_q];
`else
    assign byp_take        = 1'b0;
    assign bus.out_valid_o = !fifo_empty;
    assign bus.out_mask_o  = mask_mem[head_q];
    assign bus.out_pkg_o   = pkg_mem[head_q];
`endif

    // Empty-mask bundles are acknowledged but never occupy an entry.
    assign push  = accept && mask_nz && !byp_take && !bus.flush_i;
    assign wr_en = bus.flush_i ? flush_keep : push;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        cur_tid_d = bus.redirect_valid_i ? bus.redirect_tid_i : cur_tid_q;
        if (bus.flush_i) begin
            // Restart the queue at the current tail; the kept bundle lands there.
            head_d  = tail_q;
            tail_d  = tail_q + PTR_W'(flush_keep);
            count_d = CNT_W'(flush_keep);
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            cur_tid_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            cur_tid_q <= cur_tid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mask_mem[tail_q] <= bus.in_mask_i;
            pkg_mem[tail_q]  <= bus.in_pkg_i;
        end
    end
endmodule

// File: tb/tb_wired_dispatch_buf.sv
// Directed bench for wired_dispatch_buf: fill/full, ordered streaming with wrap,
// flush capture, redirect-tagged flush, latency/bypass, empty masks and reset.
module tb_wired_dispatch_buf;
    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int PKGW  = 64;
    localparam int TIDW  = 1;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    wired_dispatch_buf_if #(.LANES(LANES), .DEPTH(DEPTH), .PKG_WIDTH(PKGW), .TID_WIDTH(TIDW)) bus ();

    wired_dispatch_buf #(.LANES(LANES), .DEPTH(DEPTH), .PKG_WIDTH(PKGW), .TID_WIDTH(TIDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] mask_of(input int n);
        return 2'((n % 3) + 1);
    endfunction

    function automatic logic [127:0] mk_pkg(input int n);
        return {32'hA5A5_0000 + 32'(n), 32'h0000_1111, 32'h5A5A_0000 + 32'(n), 32'(n * 7)};
    endfunction

    task automatic idle();
        bus.in_valid_i       = 1'b0;
        bus.in_mask_i        = '0;
        bus.in_pkg_i         = '0;
        bus.in_tid_i         = '0;
        bus.out_ready_i      = 1'b0;
        bus.flush_i          = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_tid_i   = '0;
    endtask

    task automatic push_one(input int n, input logic [TIDW-1:0] tid);
        bus.in_valid_i = 1'b1;
        bus.in_mask_i  = mask_of(n);
        bus.in_pkg_i   = mk_pkg(n);
        bus.in_tid_i   = tid;
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    initial begin
        logic [1:0]   mq [$];
        logic [127:0] pq [$];
        int           k;
        int           cyc;
        int           sz;

        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_count", bus.count_o, 0);
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_in_ready", bus.in_ready_o, 1);

        // Fill to DEPTH with rename stalled, then offer one more while popping.
        for (int i = 0; i < DEPTH; i++) push_one(i, 1'b0);
        chk("full_count", bus.count_o, 4);
        chk("full_in_ready", bus.in_ready_o, 0);
        chk("full_head_mask", bus.out_mask_o, mask_of(0));
        bus.in_valid_i  = 1'b1;
        bus.in_mask_i   = 2'b11;
        bus.in_pkg_i    = mk_pkg(99);
        bus.out_ready_i = 1'b1;
        #1;
        chk("full_pop_ready", bus.in_ready_o, 0);
        tick();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        #1;
        chk("full_pop_count", bus.count_o, 3);
        for (int i = 1; i < DEPTH; i++) begin
            bus.out_ready_i = 1'b1;
            #1;
            chk("drain_mask", bus.out_mask_o, mask_of(i));
            chk("drain_pkg", bus.out_pkg_o, mk_pkg(i));
            tick();
        end
        bus.out_ready_i = 1'b0;
        #1;
        chk("drain_count", bus.count_o, 0);

        // Stream 10 bundles against a randomly stalling consumer.
        k   = 0;
        cyc = 0;
        while ((k < 10 || mq.size() != 0) && cyc < 200) begin
            cyc++;
            bus.in_valid_i  = (k < 10);
            bus.in_mask_i   = mask_of(k + 10);
            bus.in_pkg_i    = mk_pkg(k + 10);
            bus.out_ready_i = 1'($urandom_range(0, 1));
            #1;
            sz = mq.size();
            chk("stream_ready", bus.in_ready_o, sz < DEPTH);
`ifdef WIRED_DBUF_BYPASS_EN
            if (sz == 0) begin
                chk("stream_byp_valid", bus.out_valid_o, bus.in_valid_i);
                if (bus.in_valid_i) begin
                    chk("stream_byp_pkg", bus.out_pkg_o, mk_pkg(k + 10));
                    if (!bus.out_ready_i) begin
                        mq.push_back(mask_of(k + 10));
                        pq.push_back(mk_pkg(k + 10));
                    end
                    k++;
                end
            end else begin
`else
            begin
`endif
                chk("stream_valid", bus.out_valid_o, sz != 0);
                if (sz != 0 && bus.out_ready_i) begin
                    chk("stream_mask", bus.out_mask_o, mq[0]);
                    chk("stream_pkg", bus.out_pkg_o, pq[0]);
                    void'(mq.pop_front());
                    void'(pq.pop_front());
                end
                if (k < 10 && sz < DEPTH) begin
                    mq.push_back(mask_of(k + 10));
                    pq.push_back(mk_pkg(k + 10));
                    k++;
                end
            end
            tick();
        end
        idle();
        #1;
        chk("stream_done", (k == 10 && mq.size() == 0), 1);
        chk("stream_end_count", bus.count_o, 0);

        // Flush with a matching tag keeps the offered bundle; mismatching drops it.
        bus.redirect_valid_i = 1'b1;
        bus.redirect_tid_i   = 1'b1;
        tick();
        bus.redirect_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) push_one(30 + i, 1'b1);
        chk("fl_pre_count", bus.count_o, 3);
        bus.flush_i    = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_mask_i  = 2'b10;
        bus.in_pkg_i   = mk_pkg(40);
        bus.in_tid_i   = 1'b1;
        #1;
        chk("fl_in_ready", bus.in_ready_o, 1);
        tick();
        idle();
        #1;
        chk("fl_keep_count", bus.count_o, 1);
        chk("fl_keep_valid", bus.out_valid_o, 1);
        chk("fl_keep_mask", bus.out_mask_o, 2'b10);
        chk("fl_keep_pkg", bus.out_pkg_o, mk_pkg(40));
        for (int i = 0; i < 2; i++) push_one(41 + i, 1'b1);
        chk("fl2_pre_count", bus.count_o, 3);
        bus.flush_i    = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_mask_i  = 2'b01;
        bus.in_pkg_i   = mk_pkg(45);
        bus.in_tid_i   = 1'b0;
        bus.out_ready_i = 1'b1;
        #1;
        chk("fl2_in_ready", bus.in_ready_o, 1);
        tick();
        idle();
        #1;
        chk("fl_drop_count", bus.count_o, 0);
        chk("fl_drop_valid", bus.out_valid_o, 0);

        // Redirect in the flush cycle supplies the compare tag and updates cur_tid.
        bus.redirect_valid_i = 1'b1;
        bus.redirect_tid_i   = 1'b0;
        tick();
        bus.redirect_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) push_one(50 + i, 1'b0);
        bus.flush_i          = 1'b1;
        bus.redirect_valid_i = 1'b1;
        bus.redirect_tid_i   = 1'b1;
        bus.in_valid_i       = 1'b1;
        bus.in_mask_i        = 2'b11;
        bus.in_pkg_i         = mk_pkg(55);
        bus.in_tid_i         = 1'b1;
        tick();
        idle();
        #1;
        chk("rd_keep_count", bus.count_o, 1);
        chk("rd_keep_pkg", bus.out_pkg_o, mk_pkg(55));
        bus.out_ready_i = 1'b1;
        tick();
        idle();
        bus.flush_i    = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_mask_i  = 2'b01;
        bus.in_pkg_i   = mk_pkg(56);
        bus.in_tid_i   = 1'b1;
        tick();
        idle();
        #1;
        chk("rd_curtid_count", bus.count_o, 1);
        chk("rd_curtid_pkg", bus.out_pkg_o, mk_pkg(56));
        bus.out_ready_i = 1'b1;
        tick();
        idle();
        #1;
        chk("rd_empty", bus.count_o, 0);

        // Latency from an empty FIFO with rename ready.
        bus.in_valid_i  = 1'b1;
        bus.in_mask_i   = 2'b01;
        bus.in_pkg_i    = mk_pkg(60);
        bus.out_ready_i = 1'b1;
        #1;
`ifdef WIRED_DBUF_BYPASS_EN
        chk("lat_same_valid", bus.out_valid_o, 1);
        chk("lat_same_pkg", bus.out_pkg_o, mk_pkg(60));
        tick();
        bus.in_valid_i = 1'b0;
        #1;
        chk("lat_count", bus.count_o, 0);
        chk("lat_after_valid", bus.out_valid_o, 0);
`else
        chk("lat_same_valid", bus.out_valid_o, 0);
        tick();
        bus.in_valid_i = 1'b0;
        #1;
        chk("lat_next_valid", bus.out_valid_o, 1);
        chk("lat_count", bus.count_o, 1);
        chk("lat_next_pkg", bus.out_pkg_o, mk_pkg(60));
        tick();
        #1;
        chk("lat_drained", bus.count_o, 0);
`endif
        idle();

        // Empty-mask bundle is acknowledged and discarded.
        bus.in_valid_i = 1'b1;
        bus.in_mask_i  = 2'b00;
        bus.in_pkg_i   = mk_pkg(70);
        #1;
        chk("zm_in_ready", bus.in_ready_o, 1);
        chk("zm_out_valid", bus.out_valid_o, 0);
        tick();
        idle();
        #1;
        chk("zm_count", bus.count_o, 0);

        // Reset with two stored bundles and a competing matching flush.
        for (int i = 0; i < 2; i++) push_one(80 + i, 1'b0);
        chk("pre_rst_count", bus.count_o, 2);
        rst            = 1'b1;
        bus.flush_i    = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_mask_i  = 2'b01;
        bus.in_pkg_i   = mk_pkg(90);
        bus.in_tid_i   = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("mid_rst_count", bus.count_o, 0);
        chk("mid_rst_valid", bus.out_valid_o, 0);
        chk("mid_rst_ready", bus.in_ready_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish within 200000");
        $fatal(1, "bench timeout");
    end
endmodule
